// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the line buffer and its storage.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } lb_state_t;

  localparam uart_byte_t UART_CR = 8'h0D;
  localparam uart_byte_t UART_LF = 8'h0A;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_line_ram.sv
// DEPTH x 8 line storage: synchronous write, asynchronous read, contents not reset.
module uart_line_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  uart_byte_t      wdata,
  input  logic [AW-1:0]   raddr,
  output uart_byte_t      rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_buffer.sv
// Line buffer between UART RX and TX: collects a line, then drains it whole
// over a valid/ready handshake while dropping (and counting) new input bytes.
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int         DEPTH = 64,
  parameter uart_byte_t TERM  = UART_CR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       line_done,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  lb_state_t     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_inc;
  uart_byte_t    rd_byte;
  logic          wr_en;
  logic          fill_done;
  logic          pop;

  uart_line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  assign wr_en     = (state == FILL) && in_valid;
  assign count_inc = count + (AW+1)'(in_valid);
  // count_inc includes a byte written this cycle, so flush+write still drains.
  assign fill_done = (in_valid && (in_data == TERM))
                   || (count_inc == CNT_FULL)
                   || (flush && (count_inc != '0));

  assign busy      = (state == DRAIN);
  assign out_valid = (state == DRAIN) && (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? rd_byte : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      line_done <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      line_done <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count_inc;
          end
          if (fill_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (in_valid) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          if (pop) begin
            if (count == CNT_ONE) begin
              state     <= FILL;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              count     <= '0;
              line_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              count  <= count - 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Directed self-checking bench for uart_line_buffer; inputs change and outputs
// are checked on the falling clock edge, away from the active rising edge.
module tb_uart_line_buffer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       line_done;
  logic [7:0] drop_cnt;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_line_buffer #(
    .DEPTH (64),
    .TERM  (8'h0D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .line_done (line_done),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [7:0] exp_data,
                             input logic exp_done, input logic [7:0] exp_drop, input logic exp_busy);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(exp_data));
    chk({tag, ".line_done"}, 32'(line_done), 32'(exp_done));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(exp_drop));
    chk({tag, ".busy"},      32'(busy),      32'(exp_busy));
  endtask

  // Drive one cycle of inputs at a falling edge and advance to the next one.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic fl, input logic rdy);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;

    $display("[TB] basic line");
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
    checkOutput("basic.fill1", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b1);
    checkOutput("basic.fill2", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b1);
    checkOutput("basic.b0", 1'b1, 8'h41, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("basic.b1", 1'b1, 8'h42, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("basic.b2", 1'b1, 8'h0D, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("basic.done", 1'b0, 8'h00, 1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("basic.after", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp.hold", 1'b1, 8'h41, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("bp.hold_end", 1'b1, 8'h41, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp.b1", 1'b1, 8'h42, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp.b2", 1'b1, 8'h0D, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp.done", 1'b0, 8'h00, 1'b1, 8'd0, 1'b0);

    $display("[TB] full buffer");
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    end
    checkOutput("full.63", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("full.64", 1'b1, 8'h55, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("full.drop65", 1'b1, 8'h55, 1'b0, 8'd1, 1'b1);
    for (int i = 0; i < 64; i++) begin
      checkOutput("full.drain", 1'b1, 8'h55, 1'b0, 8'd1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("full.done", 1'b0, 8'h00, 1'b1, 8'd1, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    checkOutput("flush.pre", 1'b0, 8'h00, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush.b0", 1'b1, 8'h31, 1'b0, 8'd1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush.b1", 1'b1, 8'h32, 1'b0, 8'd1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush.done", 1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush.empty", 1'b0, 8'h00, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("flush.empty2", 1'b0, 8'h00, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("flush.with_write", 1'b1, 8'h33, 1'b0, 8'd1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush.with_write_done", 1'b0, 8'h00, 1'b1, 8'd1, 1'b0);

    $display("[TB] simultaneous events");
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    checkOutput("sim.b0", 1'b1, 8'h61, 1'b0, 8'd1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("sim.b1", 1'b1, 8'h0D, 1'b0, 8'd1, 1'b1);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b1);
    checkOutput("sim.final_drop", 1'b0, 8'h00, 1'b1, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
    checkOutput("sim.next_store", 1'b0, 8'h00, 1'b0, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    checkOutput("sim.c0", 1'b1, 8'h63, 1'b0, 8'd2, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("sim.c1", 1'b1, 8'h0D, 1'b0, 8'd2, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("sim.c_done", 1'b0, 8'h00, 1'b1, 8'd2, 1'b0);

    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h72, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h73, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h74, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    checkOutput("rst.b0", 1'b1, 8'h71, 1'b0, 8'd2, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.b1", 1'b1, 8'h72, 1'b0, 8'd2, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.b2", 1'b1, 8'h73, 1'b0, 8'd2, 1'b1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst.async", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    checkOutput("rst.held", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
    checkOutput("rst.new_b0", 1'b1, 8'h0D, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst.new_done", 1'b0, 8'h00, 1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst.new_idle", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_line_buffer.md
# uart_line_buffer

Line-oriented byte buffer between the UART receiver and the UART transmitter. It collects received bytes until a terminator byte, a full buffer, or a flush request. It then releases the whole line, in order, to the transmitter through a valid/ready handshake. Bytes arriving while a line is being drained are dropped and counted, so the echo path never interleaves two lines.

## Interface
- `DEPTH`, 64: buffer capacity in bytes; power of two, minimum 4.
- `TERM`, 8'h0D: terminator byte; stored as the last byte of the line.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  single-cycle strobe from the receiver when a byte is complete.
- `in_data`  in  8  received byte; qualified by `in_valid`.
- `flush`  in  1  single-cycle request to release a partial line.
- `out_valid`  out  1  a buffered byte is presented to the transmitter.
- `out_data`  out  8  byte at the read pointer; 8'h00 whenever `out_valid` = 0.
- `out_ready`  in  1  transmitter accepts `out_data` this cycle.
- `line_done`  out  1  one-cycle pulse on the cycle after the last byte of a line is popped.
- `drop_cnt`  out  8  number of dropped input bytes; saturates at 255.
- `busy`  out  1  high while in DRAIN.

## Operation
- Two states: FILL and DRAIN. Reset state is FILL.
- Internal state:
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide.
  - `count` is log2(DEPTH)+1 bits wide, range 0..DEPTH.
- FILL:
  - Each `in_valid` stores `in_data` at `wr_ptr`, then increments `wr_ptr` and `count`.
  - Go to DRAIN if the stored byte equals `TERM`, if `count` becomes DEPTH, or if `flush` is asserted while `count` > 0 (counting the byte written that cycle).
  - `flush` with `count` = 0 and no write in the same cycle is ignored.
  - A terminator that also fills the buffer causes one DRAIN entry.
- DRAIN:
  - `out_valid` = 1 while `count` > 0.
  - A pop occurs on `out_valid` && `out_ready`: `rd_ptr` increments and `count` decrements.
  - When the popping byte is the last one (`count` = 1), go to FILL and pulse `line_done` on the next cycle.
  - On entering FILL, `wr_ptr` and `rd_ptr` both reset to 0.
- Drop rule: `in_valid` in DRAIN, including the cycle of the final pop, is discarded and `drop_cnt` increments (saturating). `flush` in DRAIN is ignored.
- `out_data` follows `rd_ptr` combinationally from the buffer and is gated to 0 when `out_valid` = 0.
- `out_valid`, once high, stays high until the last pop; the transmitter may hold `out_ready` low indefinitely.

## Timing
- Reset values: state FILL, pointers and `count` 0, `out_valid` 0, `out_data` 8'h00, `line_done` 0, `drop_cnt` 0, `busy` 0.
- Reset mid-line (FILL or DRAIN): everything above returns to its reset value on assertion; buffered data is lost.
- Latency: the terminator write at cycle N gives `out_valid` = 1 with the first byte at N+1.
- Pop at cycle M presents the next byte at M+1. Back-to-back pops are allowed, giving 1 byte per cycle.
- Final pop at cycle M: `out_valid` = 0, `busy` = 0 and `line_done` = 1 at M+1. An `in_valid` at M+1 is accepted.
- `in_valid` and `flush` in the same FILL cycle: the byte is stored, then DRAIN.
- Buffer contents are not reset; only pointers and `count` are.

## Structure
- Shared package `uart_pkg`:
  - state enum `lb_state_t` (FILL, DRAIN);
  - `UART_CR` (8'h0D) and `UART_LF` (8'h0A) constants;
  - byte typedef `uart_byte_t`.
- Sub-module `uart_line_ram`: DEPTH×8 storage, one synchronous write port and one asynchronous read port.
- The state machine, pointers, counters and drop logic stay in `uart_line_buffer`.

## Test plan
- **Basic line:** in FILL, write 8'h41, 8'h42, 8'h0D with `out_ready` = 1 → `out_data` is 41, 42, 0D on consecutive cycles; `line_done` pulses once; `drop_cnt` = 0.
- **Back-pressure:** same line with `out_ready` low for 20 cycles, then high → `out_valid` held with 8'h41 stable throughout; order preserved.
- **Full buffer:** 64 bytes of 8'h55 with no terminator → DRAIN after the 64th byte; exactly 64 bytes out; a 65th input during DRAIN makes `drop_cnt` = 1.
- **Flush:** write 8'h31, 8'h32, then `flush` → 31, 32 released. A `flush` alone with an empty buffer gives no `out_valid`.
- **Simultaneous events:** `in_valid` on the final-pop cycle → dropped, `drop_cnt` increments. `in_valid` on the cycle after → stored.
- **Reset mid-drain:** assert `rst` after 2 of 5 bytes have been popped → all outputs return to reset values. A new line 8'h0D then drains as a single byte.
